// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, arbiter FSM encoding and request payload.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h2;
  localparam logic [OP_W-1:0] OP_INC  = 4'h3;
  localparam logic [OP_W-1:0] OP_DEC  = 4'h4;
  localparam logic [OP_W-1:0] OP_AND  = 4'h5;
  localparam logic [OP_W-1:0] OP_OR   = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT  = 4'h7;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
  localparam logic [OP_W-1:0] OP_XNOR = 4'h9;
  localparam logic [OP_W-1:0] OP_NAND = 4'hA;
  localparam logic [OP_W-1:0] OP_NOR  = 4'hB;
  localparam logic [OP_W-1:0] OP_SHL  = 4'hC;
  localparam logic [OP_W-1:0] OP_SHR  = 4'hD;
  localparam logic [OP_W-1:0] OP_ROL  = 4'hE;
  localparam logic [OP_W-1:0] OP_ROR  = 4'hF;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic              sel;
  } alu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above the
// pointer, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_any
);

  logic [ID_W-1:0] w_idx;
  logic            w_hit;

  // Walk the requesters in priority order starting at the pointer.
  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_hit    = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_hit && i_req[w_idx]) begin
        w_hit        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = w_idx;
      end
    end
    o_any = w_hit;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Sequences one shared ALU between NUM_REQ requesters: accept, execute for one
// cycle, then hold the registered result until the winner takes it.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ-1:0]        req_sel,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_opcode,
  output logic                      alu_in_sel,
  output logic                      alu_enable,
  output logic                      alu_reset,
  input  logic [DATA_W-1:0]         alu_out,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_state_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_gid;
  logic [ID_W-1:0]    w_gid;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic               w_accept;
  logic               w_rsp_done;
  alu_req_t           r_req;
  alu_req_t           w_req;
  logic [DATA_W-1:0]  r_result;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gid),
    .o_any    (w_any)
  );

  // Payload of the current winner.
  always_comb begin
    w_req     = '0;
    w_req.a   = req_a[{w_gid, 3'b000} +: DATA_W];
    w_req.b   = req_b[{w_gid, 3'b000} +: DATA_W];
    w_req.op  = req_op[{w_gid, 2'b00} +: OP_W];
    w_req.sel = req_sel[w_gid];
  end

  assign w_accept   = (r_state == ST_IDLE) && w_any;
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_gid];
  assign w_ptr_nxt  = ID_W'((32'(w_gid) + 32'd1) % NUM_REQ);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched operation, winner, pointer and captured ALU result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req    <= '0;
      r_gid    <= '0;
      r_ptr    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_req <= w_req;
        r_gid <= w_gid;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == ST_EXEC) r_result <= alu_out;
    end
  end

  assign req_ready  = (!reset && w_accept) ? w_gnt : '0;
  assign rsp_valid  = (r_state == ST_RESP) ? (NUM_REQ'(1) << r_gid) : '0;
  assign rsp_data   = r_result;
  assign alu_a      = r_req.a;
  assign alu_b      = r_req.b;
  assign alu_opcode = r_req.op;
  assign alu_in_sel = r_req.sel;
  assign alu_enable = (r_state == ST_EXEC);
  assign alu_reset  = reset;
  assign busy       = (r_state != ST_IDLE);
  assign grant_id   = r_gid;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: transaction-level model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_ready, req_sel, rsp_valid, rsp_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [N*4-1:0] req_op;
  logic [7:0]    rsp_data, alu_a, alu_b, alu_out, junk;
  logic [3:0]    alu_opcode;
  logic          alu_in_sel, alu_enable, alu_reset, busy;
  logic [IW-1:0] grant_id;

  int n_chk = 0;
  int n_pass = 0;
  int en_cnt = 0;
  bit chk_en = 1'b0;
  int rq_id[$];
  logic [7:0] rq_dat[$];

  always #5 clk = ~clk;

  alu_req_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_in_sel(alu_in_sel),
    .alu_enable(alu_enable), .alu_reset(alu_reset), .alu_out(alu_out),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op, input logic sel);
    logic [7:0]  s;
    logic [15:0] p;
    s = sel ? a : b;
    p = {8'd0, a} * {8'd0, b};
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return p[7:0];
      OP_INC:  return s + 8'd1;
      OP_DEC:  return s - 8'd1;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOT:  return ~s;
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_SHL:  return {s[6:0], 1'b0};
      OP_SHR:  return {1'b0, s[7:1]};
      OP_ROL:  return {s[6:0], s[7]};
      default: return {s[0], s[7:1]};
    endcase
  endfunction

  // Stand-in ALU: outputs garbage unless enabled, so only the EXEC capture is usable.
  always @(posedge clk) junk <= 8'($urandom);
  assign alu_out = alu_enable ? alu_f(alu_a, alu_b, alu_opcode, alu_in_sel) : junk;

  // Round-robin rule: lowest valid index >= pointer, else lowest valid overall.
  function automatic void pick(input logic [N-1:0] v, input logic [IW-1:0] p,
                               output logic hit, output logic [IW-1:0] w);
    hit = 1'b0;
    w   = '0;
    for (int j = N - 1; j >= 0; j--)
      if (v[IW'(j)] && IW'(j) >= p) begin hit = 1'b1; w = IW'(j); end
    if (!hit)
      for (int j = N - 1; j >= 0; j--)
        if (v[IW'(j)]) begin hit = 1'b1; w = IW'(j); end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Model: idle or holding one operation; age counts cycles since its accept.
  logic          m_pend = 1'b0;
  logic [1:0]    m_age = '0;
  logic [IW-1:0] m_g = '0, m_ptr = '0;
  logic [7:0]    m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]    m_op = '0;
  logic          m_sel = 1'b0;
  logic [N-1:0]  m_acc = '0;

  always @(posedge clk) begin : model_upd
    logic          hit;
    logic [IW-1:0] w;
    logic [7:0]    pa, pb;
    logic [3:0]    po;
    logic [N-1:0]  acc;
    pick(req_valid, m_ptr, hit, w);
    acc = '0;
    pa = req_a[{w, 3'b000} +: 8];
    pb = req_b[{w, 3'b000} +: 8];
    po = req_op[{w, 2'b00} +: 4];
    if (reset) begin
      m_pend <= 1'b0; m_age <= '0; m_g <= '0; m_ptr <= '0;
      m_a <= '0; m_b <= '0; m_op <= '0; m_sel <= 1'b0;
    end else if (!m_pend) begin
      if (hit) begin
        acc[w] = 1'b1;
        m_g <= w; m_a <= pa; m_b <= pb; m_op <= po; m_sel <= req_sel[w];
        m_res <= alu_f(pa, pb, po, req_sel[w]);
        m_ptr <= IW'((int'(w) + 1) % N);
        m_pend <= 1'b1; m_age <= 2'd1;
      end
    end else if (m_age >= 2'd2 && rsp_ready[m_g]) begin
      m_pend <= 1'b0;
    end else begin
      m_age <= 2'd2;
    end
    m_acc <= acc;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin : compare
    logic          hit;
    logic [IW-1:0] w;
    logic [N-1:0]  e_rr, e_rv;
    if (chk_en) begin
      pick(req_valid, m_ptr, hit, w);
      e_rr = '0;
      if (!reset && !m_pend && hit) e_rr[w] = 1'b1;
      e_rv = '0;
      if (m_pend && m_age >= 2'd2) e_rv[m_g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(e_rr));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("busy", 32'(busy), 32'(m_pend));
      chk("alu_enable", 32'(alu_enable), 32'(m_pend && m_age == 2'd1));
      chk("grant_id", 32'(grant_id), 32'(m_g));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
      chk("alu_in_sel", 32'(alu_in_sel), 32'(m_sel));
      chk("alu_reset", 32'(alu_reset), 32'(reset));
      if (e_rv != 0) chk("rsp_data", 32'(rsp_data), 32'(m_res));
    end
  end

  // Completed responses as seen on the DUT pins.
  always @(negedge clk) begin
    if (alu_enable === 1'b1) en_cnt++;
    if (!reset && (rsp_valid & rsp_ready) != 0) begin
      for (int j = 0; j < N; j++)
        if (rsp_valid[IW'(j)] && rsp_ready[IW'(j)]) rq_id.push_back(j);
      rq_dat.push_back(rsp_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_drop();
    step();
    req_valid = req_valid & ~m_acc;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic sel);
    logic [IW-1:0] ix;
    ix = IW'(i);
    req_a[{ix, 3'b000} +: 8] = a;
    req_b[{ix, 3'b000} +: 8] = b;
    req_op[{ix, 2'b00} +: 4] = op;
    req_sel[ix]   = sel;
    req_valid[ix] = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((req_valid != 0 || m_pend) && k < max) begin
      step_drop();
      k++;
    end
    chk("idle_timeout", 32'(req_valid != 0 || m_pend), 32'(0));
  endtask

  initial begin
    int base, acc, k;
    int exp_id[5];
    logic [7:0] exp_dat[5];
    exp_id  = '{0, 1, 2, 3, 0};
    exp_dat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    req_sel = '0; rsp_ready = '0;
    step();
    chk_en = 1'b1;
    req_valid = 4'b1010;
    step();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_reset", 32'(alu_reset), 32'(1));
    req_valid = '0; reset = 1'b0; rsp_ready = '1;

    // All four held valid with INC a=i: order 0,1,2,3,0.
    base = rq_id.size();
    for (int i = 0; i < N; i++) set_req(i, 8'(i), 8'($urandom), OP_INC, 1'b1);
    acc = 0; k = 0;
    while (acc < 5 && k < 40) begin
      step();
      if (m_acc != 0) acc++;
      k++;
    end
    req_valid = '0;
    wait_idle(20);
    chk("rr_count", 32'(rq_id.size() - base), 32'(5));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_id%0d", i), 32'(rq_id[base+i]), 32'(exp_id[i]));
      chk($sformatf("rr_data%0d", i), 32'(rq_dat[base+i]), 32'(exp_dat[i]));
    end

    // Single ADD: enable for one cycle, response two cycles after accept.
    base = rq_id.size(); en_cnt = 0;
    set_req(0, 8'h35, 8'h0A, OP_ADD, 1'b0);
    step_drop();
    chk("add_t1_enable", 32'(alu_enable), 32'(1));
    step_drop();
    chk("add_t2_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    chk("add_t2_rsp_data", 32'(rsp_data), 32'h3F);
    step_drop();
    chk("add_t3_busy", 32'(busy), 32'(0));
    wait_idle(10);
    chk("add_en_cycles", 32'(en_cnt), 32'(1));
    chk("add_rsp_data", 32'(rq_dat[base]), 32'h3F);

    // Pointer at 3 after granting 2; 0 and 3 valid -> 3 then 0.
    set_req(2, 8'h11, 8'h22, OP_OR, 1'b0);
    wait_idle(10);
    base = rq_id.size();
    set_req(0, 8'hAA, 8'h0F, OP_XOR, 1'b0);
    set_req(3, 8'h81, 8'h00, OP_ROL, 1'b1);
    wait_idle(20);
    chk("ptr_first_id", 32'(rq_id[base]), 32'(3));
    chk("ptr_first_data", 32'(rq_dat[base]), 32'h03);
    chk("ptr_second_id", 32'(rq_id[base+1]), 32'(0));
    chk("ptr_second_data", 32'(rq_dat[base+1]), 32'hA5);

    // Truncation of MUL and SUB.
    base = rq_id.size();
    set_req(1, 8'h10, 8'h10, OP_MUL, 1'b0);
    wait_idle(10);
    set_req(1, 8'h00, 8'h01, OP_SUB, 1'b0);
    wait_idle(10);
    chk("mul_data", 32'(rq_dat[base]), 32'h00);
    chk("sub_data", 32'(rq_dat[base+1]), 32'hFF);

    // Response back-pressure on requester 1 for five cycles.
    base = rq_id.size(); en_cnt = 0;
    rsp_ready = 4'b1101;
    set_req(1, 8'hF0, 8'h3C, OP_AND, 1'b0);
    k = 0;
    while (rsp_valid[1] !== 1'b1 && k < 10) begin step_drop(); k++; end
    chk("hold_timeout", 32'(rsp_valid[1] !== 1'b1), 32'(0));
    set_req(2, 8'h01, 8'h02, OP_OR, 1'b0);
    en_cnt = 0;
    repeat (5) begin
      step_drop();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
      chk("hold_rsp_data", 32'(rsp_data), 32'h30);
      chk("hold_req_ready", 32'(req_ready), 32'(0));
    end
    chk("hold_enable_cycles", 32'(en_cnt), 32'(0));
    rsp_ready = '1;
    wait_idle(20);
    chk("hold_id", 32'(rq_id[base]), 32'(1));
    chk("hold_next_data", 32'(rq_dat[base+1]), 32'h03);

    // Reset during EXEC drops the operation and clears the pointer.
    set_req(0, 8'h12, 8'h34, OP_XOR, 1'b0);
    step_drop();
    chk("rexec_enable", 32'(alu_enable), 32'(1));
    base = rq_id.size();
    reset = 1'b1;
    step_drop();
    chk("rexec_busy", 32'(busy), 32'(0));
    chk("rexec_grant_id", 32'(grant_id), 32'(0));
    chk("rexec_rsp_valid", 32'(rsp_valid), 32'(0));
    reset = 1'b0;
    repeat (3) step_drop();
    chk("rexec_no_rsp", 32'(rq_id.size() - base), 32'(0));
    set_req(0, 8'h01, 8'h02, OP_ADD, 1'b0);
    set_req(3, 8'h05, 8'h05, OP_ADD, 1'b0);
    wait_idle(20);
    chk("rexec_first_id", 32'(rq_id[base]), 32'(0));
    chk("rexec_first_data", 32'(rq_dat[base]), 32'h03);
    chk("rexec_second_id", 32'(rq_id[base+1]), 32'(3));
    chk("rexec_second_data", 32'(rq_dat[base+1]), 32'h0A);

    // Random traffic with back-pressure and occasional resets.
    repeat (1500) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(199) == 0) reset = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[IW'(i)] && m_acc[IW'(i)]) begin
          if ($urandom_range(1) == 1)
            set_req(i, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
          else
            req_valid[IW'(i)] = 1'b0;
        end else if (!req_valid[IW'(i)] && $urandom_range(3) == 0) begin
          set_req(i, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
        end
      end
      rsp_ready = 4'($urandom);
    end
    reset = 1'b0;
    rsp_ready = '1;
    wait_idle(60);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
